pwm_hit_sequencer: RTL and testbench

- Controller that sits in front of PWMSerializer and drives its duty_cycle and hit inputs.
- Two requesters, e.g. player-0 and player-1 hit detectors, each ask for a feedback pulse at a requested strength.
- The block arbitrates round-robin, then plays one trapezoidal envelope: ramp up, hold, ramp down, gap.
- Only one channel owns the serializer at a time.

---
 rtl/pwm_hit_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_pwm_hit_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_hit_sequencer.sv
// pwm_hit_sequencer
//   Front end for PWMSerializer. Two requesters each ask for a haptic pulse at
//   a given peak strength. Requests are arbitrated round-robin and the winner
//   gets one trapezoidal envelope: ramp up, hold at peak, ramp down, forced gap.
//   Only one channel owns the serializer at a time.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   req[1:0]    per-channel request level, held high until ack is seen
//   level0/1    requested peak duty per channel, sampled at grant
//   abort       synchronous early end of the current pulse (RAMP_UP/HOLD only)
//   ack[1:0]    one-cycle one-hot grant pulse
//   duty_cycle  envelope value to PWMSerializer
//   hit[1:0]    one-hot active channel to PWMSerializer, 00 when no pulse
//   busy        high in every state except IDLE
module pwm_hit_sequencer #(
    parameter int TICK_CYCLES = 100000,
    parameter int STEP        = 10,
    parameter int MAX_DUTY    = 99,
    parameter int HOLD_TICKS  = 20,
    parameter int GAP_TICKS   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [6:0] level0,
    input  logic [6:0] level1,
    input  logic       abort,
    output logic [1:0] ack,
    output logic [6:0] duty_cycle,
    output logic [1:0] hit,
    output logic       busy
);

    localparam int TCW      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int HOLD_EFF = (HOLD_TICKS == 0) ? 1 : HOLD_TICKS;
    localparam int GAP_EFF  = (GAP_TICKS == 0) ? 1 : GAP_TICKS;
    localparam int PCNT_MAX = (HOLD_EFF > GAP_EFF) ? HOLD_EFF : GAP_EFF;
    localparam int PCW      = $clog2(PCNT_MAX + 1);

    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_CYCLES - 1);
    localparam logic [PCW-1:0] HOLD_LAST = PCW'(HOLD_EFF - 1);
    localparam logic [PCW-1:0] GAP_LAST  = PCW'(GAP_EFF - 1);
    localparam logic [7:0]     STEP8     = 8'(STEP);
    localparam logic [6:0]     MAX7      = 7'(MAX_DUTY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP_UP,
        S_HOLD,
        S_RAMP_DOWN,
        S_GAP
    } state_t;

    state_t           r_state, w_state;
    logic [TCW-1:0]   r_tick_cnt, w_tick_cnt;
    logic [PCW-1:0]   r_pcnt, w_pcnt;
    logic             r_last_grant, w_last_grant;
    logic [6:0]       r_target, w_target;
    logic [6:0]       r_duty, w_duty;
    logic [1:0]       r_hit, w_hit;
    logic [1:0]       r_ack, w_ack;
    logic             r_busy, w_busy;

    logic             w_tick;
    logic             w_winner;
    logic [6:0]       w_level;
    logic [7:0]       w_sum;
    logic [7:0]       w_diff;

    assign w_tick = (r_state != S_IDLE) && (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_tick_cnt   <= '0;
            r_pcnt       <= '0;
            r_last_grant <= 1'b1;
            r_target     <= '0;
            r_duty       <= '0;
            r_hit        <= '0;
            r_ack        <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_tick_cnt   <= w_tick_cnt;
            r_pcnt       <= w_pcnt;
            r_last_grant <= w_last_grant;
            r_target     <= w_target;
            r_duty       <= w_duty;
            r_hit        <= w_hit;
            r_ack        <= w_ack;
            r_busy       <= w_busy;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_tick_cnt   = r_tick_cnt;
        w_pcnt       = r_pcnt;
        w_last_grant = r_last_grant;
        w_target     = r_target;
        w_duty       = r_duty;
        w_hit        = r_hit;
        w_ack        = '0;
        w_winner     = 1'b0;
        w_level      = '0;
        w_sum        = {1'b0, r_duty} + STEP8;
        w_diff       = {1'b0, r_duty} - STEP8;

        if (r_state != S_IDLE) begin
            w_tick_cnt = w_tick ? '0 : r_tick_cnt + TCW'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (req != 2'b00) begin
                    // On a tie the channel that did not win last time goes.
                    w_winner     = (req == 2'b11) ? ~r_last_grant : req[1];
                    w_level      = w_winner ? level1 : level0;
                    w_last_grant = w_winner;
                    w_ack        = w_winner ? 2'b10 : 2'b01;
                    w_target     = (w_level > MAX7) ? MAX7 : w_level;
                    w_duty       = '0;
                    w_tick_cnt   = '0;
                    w_pcnt       = '0;
                    if (w_target != '0) begin
                        w_hit   = w_ack;
                        w_state = S_RAMP_UP;
                    end else begin
                        w_hit   = '0;
                        w_state = S_GAP;
                    end
                end
            end

            S_RAMP_UP: begin
                if (abort) begin
                    w_state = S_RAMP_DOWN;
                end else if (w_tick) begin
                    if (w_sum >= {1'b0, r_target}) begin
                        w_duty  = r_target;
                        w_state = S_HOLD;
                        w_pcnt  = '0;
                    end else begin
                        w_duty = w_sum[6:0];
                    end
                end
            end

            S_HOLD: begin
                if (abort) begin
                    w_state = S_RAMP_DOWN;
                end else if (w_tick) begin
                    if (r_pcnt == HOLD_LAST) begin
                        w_state = S_RAMP_DOWN;
                    end else begin
                        w_pcnt = r_pcnt + PCW'(1);
                    end
                end
            end

            S_RAMP_DOWN: begin
                if (w_tick) begin
                    // Saturate at zero instead of wrapping below STEP.
                    if ({1'b0, r_duty} <= STEP8) begin
                        w_duty  = '0;
                        w_hit   = '0;
                        w_state = S_GAP;
                        w_pcnt  = '0;
                    end else begin
                        w_duty = w_diff[6:0];
                    end
                end
            end

            S_GAP: begin
                w_duty = '0;
                w_hit  = '0;
                if (w_tick) begin
                    if (r_pcnt == GAP_LAST) begin
                        w_state = S_IDLE;
                    end else begin
                        w_pcnt = r_pcnt + PCW'(1);
                    end
                end
            end

            default: begin
                w_state = S_IDLE;
                w_duty  = '0;
                w_hit   = '0;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    assign ack        = r_ack;
    assign duty_cycle = r_duty;
    assign hit        = r_hit;
    assign busy       = r_busy;

endmodule

// File: tb/tb_pwm_hit_sequencer.sv
module tb_pwm_hit_sequencer;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [6:0] level0;
    logic [6:0] level1;
    logic       abort;
    logic [1:0] ack;
    logic [6:0] duty_cycle;
    logic [1:0] hit;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    pwm_hit_sequencer #(
        .TICK_CYCLES(4),
        .STEP(10),
        .MAX_DUTY(99),
        .HOLD_TICKS(2),
        .GAP_TICKS(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .level0(level0),
        .level1(level1),
        .abort(abort),
        .ack(ack),
        .duty_cycle(duty_cycle),
        .hit(hit),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [6:0] l0;
        logic [6:0] l1;
        logic       ab;
        int         adv;
        logic [1:0] e_ack;
        logic [1:0] e_hit;
        logic [6:0] e_duty;
        logic       e_busy;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic [1:0] r, input int a0, input int a1,
                                input logic ab, input int adv, input logic [1:0] ea,
                                input logic [1:0] eh, input int ed, input logic eb);
        vec_t v;
        v.req    = r;
        v.l0     = 7'(a0);
        v.l1     = 7'(a1);
        v.ab     = ab;
        v.adv    = adv;
        v.e_ack  = ea;
        v.e_hit  = eh;
        v.e_duty = 7'(ed);
        v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(busy), 0);
    endtask

    // Safety invariants checked every cycle.
    always @(negedge clk) begin
        n_cmp++;
        if (duty_cycle > 7'd99 || hit == 2'b11 || ack == 2'b11) begin
            n_bad++;
            $display("FAIL invariant: duty=%0d hit=%b ack=%b, required duty<=99 and one-hot", duty_cycle, hit, ack);
        end
    end

    initial begin
        // Single request, level0=25; level0 changed after grant must be ignored.
        vecs[0]  = mk(2'b01, 25, 0, 1'b0, 1, 2'b01, 2'b01, 0, 1'b1);
        vecs[1]  = mk(2'b00, 90, 0, 1'b0, 1, 2'b00, 2'b01, 0, 1'b1);
        vecs[2]  = mk(2'b00, 90, 0, 1'b0, 3, 2'b00, 2'b01, 10, 1'b1);
        vecs[3]  = mk(2'b00, 90, 0, 1'b0, 3, 2'b00, 2'b01, 10, 1'b1);
        vecs[4]  = mk(2'b00, 90, 0, 1'b0, 1, 2'b00, 2'b01, 20, 1'b1);
        vecs[5]  = mk(2'b00, 90, 0, 1'b0, 4, 2'b00, 2'b01, 25, 1'b1);
        vecs[6]  = mk(2'b00, 90, 0, 1'b0, 8, 2'b00, 2'b01, 25, 1'b1);
        vecs[7]  = mk(2'b00, 90, 0, 1'b0, 4, 2'b00, 2'b01, 15, 1'b1);
        vecs[8]  = mk(2'b00, 90, 0, 1'b0, 4, 2'b00, 2'b01, 5, 1'b1);
        vecs[9]  = mk(2'b00, 90, 0, 1'b0, 4, 2'b00, 2'b00, 0, 1'b1);
        vecs[10] = mk(2'b00, 90, 0, 1'b0, 3, 2'b00, 2'b00, 0, 1'b1);
        vecs[11] = mk(2'b00, 90, 0, 1'b0, 1, 2'b00, 2'b00, 0, 1'b0);
        // Clamp: level1=120 peaks at 99.
        vecs[12] = mk(2'b10, 0, 120, 1'b0, 1, 2'b10, 2'b10, 0, 1'b1);
        vecs[13] = mk(2'b00, 0, 120, 1'b0, 4, 2'b00, 2'b10, 10, 1'b1);
        vecs[14] = mk(2'b00, 0, 120, 1'b0, 32, 2'b00, 2'b10, 90, 1'b1);
        vecs[15] = mk(2'b00, 0, 120, 1'b0, 4, 2'b00, 2'b10, 99, 1'b1);
        vecs[16] = mk(2'b00, 0, 120, 1'b0, 8, 2'b00, 2'b10, 99, 1'b1);
        vecs[17] = mk(2'b00, 0, 120, 1'b0, 4, 2'b00, 2'b10, 89, 1'b1);
        vecs[18] = mk(2'b00, 0, 120, 1'b0, 32, 2'b00, 2'b10, 9, 1'b1);
        vecs[19] = mk(2'b00, 0, 120, 1'b0, 4, 2'b00, 2'b00, 0, 1'b1);
        vecs[20] = mk(2'b00, 0, 120, 1'b0, 4, 2'b00, 2'b00, 0, 1'b0);

        reset  = 1'b1;
        req    = 2'b00;
        level0 = '0;
        level1 = '0;
        abort  = 1'b0;
        #1;
        chk("reset_duty", int'(duty_cycle), 0);
        chk("reset_hit", int'(hit), 0);
        chk("reset_ack", int'(ack), 0);
        chk("reset_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            req    = vecs[i].req;
            level0 = vecs[i].l0;
            level1 = vecs[i].l1;
            abort  = vecs[i].ab;
            repeat (vecs[i].adv) @(negedge clk);
            chk($sformatf("row%0d_ack", i), int'(ack), int'(vecs[i].e_ack));
            chk($sformatf("row%0d_hit", i), int'(hit), int'(vecs[i].e_hit));
            chk($sformatf("row%0d_duty", i), int'(duty_cycle), int'(vecs[i].e_duty));
            chk($sformatf("row%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
        end

        // Tie from reset: channel 0 first, channel 1 held off until GAP ends.
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        req    = 2'b11;
        level0 = 7'd25;
        level1 = 7'd30;
        @(negedge clk);
        chk("tie_ack0", int'(ack), 1);
        chk("tie_hit0", int'(hit), 1);
        req = 2'b10;
        for (int i = 2; i <= 37; i++) begin
            @(negedge clk);
            chk($sformatf("tie_holdoff_c%0d", i), int'(ack), 0);
        end
        chk("tie_idle0", int'(busy), 0);
        @(negedge clk);
        chk("tie_ack1", int'(ack), 2);
        chk("tie_hit1", int'(hit), 2);
        req = 2'b00;
        @(negedge clk);
        wait_idle("tie_idle1");
        req = 2'b11;
        @(negedge clk);
        chk("tie_rr_ack", int'(ack), 1);
        req = 2'b00;
        @(negedge clk);
        wait_idle("tie_idle2");

        // Abort during HOLD, then abort in GAP.
        req    = 2'b01;
        level0 = 7'd50;
        @(negedge clk);
        chk("abort_ack", int'(ack), 1);
        req = 2'b00;
        repeat (20) @(negedge clk);
        chk("abort_peak", int'(duty_cycle), 50);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_duty_held", int'(duty_cycle), 50);
        chk("abort_hit_held", int'(hit), 1);
        @(negedge clk);
        chk("abort_duty_pre_tick", int'(duty_cycle), 50);
        @(negedge clk);
        chk("abort_down40", int'(duty_cycle), 40);
        repeat (16) @(negedge clk);
        chk("abort_down0", int'(duty_cycle), 0);
        chk("abort_hit_off", int'(hit), 0);
        chk("abort_gap_busy", int'(busy), 1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("gap_abort_busy", int'(busy), 1);
        chk("gap_abort_duty", int'(duty_cycle), 0);
        @(negedge clk);
        chk("gap_busy_last", int'(busy), 1);
        @(negedge clk);
        chk("gap_done", int'(busy), 0);

        // Zero level: straight to GAP with no hit.
        req    = 2'b01;
        level0 = 7'd0;
        @(negedge clk);
        chk("zero_ack", int'(ack), 1);
        chk("zero_hit", int'(hit), 0);
        chk("zero_duty", int'(duty_cycle), 0);
        chk("zero_busy", int'(busy), 1);
        req = 2'b00;
        repeat (3) @(negedge clk);
        chk("zero_busy_last", int'(busy), 1);
        @(negedge clk);
        chk("zero_done", int'(busy), 0);

        // Reset mid-RAMP_UP, then tie after release goes to channel 0.
        req    = 2'b01;
        level0 = 7'd50;
        @(negedge clk);
        chk("rst_ack", int'(ack), 1);
        req = 2'b00;
        repeat (8) @(negedge clk);
        chk("rst_duty20", int'(duty_cycle), 20);
        @(negedge clk);
        reset = 1'b1;
        req   = 2'b11;
        #1;
        chk("rst_async_duty", int'(duty_cycle), 0);
        chk("rst_async_hit", int'(hit), 0);
        chk("rst_async_busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_after_ack", int'(ack), 1);
        chk("rst_after_hit", int'(hit), 1);
        req = 2'b00;
        wait_idle("rst_final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
